// File: rtl/mxv_pkg.sv
// Shared constants, command codes and sequencer states for the matrix-by-vector command front end.
// Also holds the expected LEN for each command, which depends on the current dimension N.
package mxv_pkg;

    localparam int DW    = 8;
    localparam int MAX_N = 8;

    localparam logic [7:0] SOF = 8'hFE;
    localparam logic [7:0] EOF = 8'hEF;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_SET_N  = 3'd1,
        CMD_RESEND = 3'd2,
        CMD_START  = 3'd3,
        CMD_LOAD_M = 3'd4,
        CMD_LOAD_V = 3'd5
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_CMD,
        S_PAYLOAD,
        S_EOF,
        S_EXEC,
        S_WAIT_DONE
    } state_e;

    // LEN counts CMD plus payload, so every legal value is at least 1.
    function automatic logic [7:0] expected_len(input cmd_e cmd, input logic [3:0] n);
        logic [7:0] n8;
        n8 = {4'd0, n};
        case (cmd)
            CMD_SET_N:             expected_len = 8'd2;
            CMD_RESEND, CMD_START: expected_len = 8'd1;
            CMD_LOAD_M:            expected_len = n8 * n8 + 8'd1;
            CMD_LOAD_V:            expected_len = n8 + 8'd1;
            default:               expected_len = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/mxv_frame_timeout.sv
// Mid-frame inactivity timer: reloads on every received byte, counts down while a frame is open.
// Latency: expire is combinational from the count; a reload in the same cycle always suppresses it.
// Backpressure: none, a pure observer of the byte strobe.
module mxv_frame_timeout #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            cnt_q <= CW'(TIMEOUT - 1);
        end else if (run && cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign expire = run && !reload && (cnt_q == '0);

endmodule

// File: rtl/mxv_cmd_sequencer.sv
// Frame parser/sequencer: decodes UART command frames, routes payload into row/vector FIFOs, fires start/resend.
// Latency: pushes and all pulses are registered, one cycle after the byte or state that causes them.
// Backpressure: none on rx; frames arriving while a compute runs are rejected with err.
module mxv_cmd_sequencer #(
    parameter int DW      = mxv_pkg::DW,
    parameter int MAX_N   = mxv_pkg::MAX_N,
    parameter int TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    rx_data,
    input  logic             rx_valid,
    input  logic             mxv_done,
    output logic [DW-1:0]    fifo_data,
    output logic [MAX_N:0]   push_sel,
    output logic             fifo_clr,
    output logic [3:0]       n_cfg,
    output logic             mxv_start,
    output logic             resend,
    output logic [2:0]       cmd_code,
    output logic             busy,
    output logic             err
);

    import mxv_pkg::*;

    localparam int PW = MAX_N + 1;

    state_e         state_q, state_nxt;
    cmd_e           cmd_q, cmd_nxt;
    logic [DW-1:0]  len_q, len_nxt;
    logic [DW-1:0]  rem_q, rem_nxt;
    logic [DW-1:0]  narg_q, narg_nxt;
    logic [3:0]     col_q, col_nxt;
    logic [3:0]     row_q, row_nxt;
    logic           m_ok, m_ok_nxt;
    logic           v_ok, v_ok_nxt;
    logic [3:0]     n_nxt;
    logic [2:0]     code_nxt;
    logic           busy_nxt;
    logic [DW-1:0]  data_nxt;
    logic [PW-1:0]  push_nxt;
    logic           clr_nxt, start_nxt, resend_nxt, err_nxt;

    logic           tmo_run, tmo_expire;
    logic           cmd_legal;
    cmd_e           rx_cmd;

    assign tmo_run   = (state_q == S_LEN) || (state_q == S_CMD) ||
                       (state_q == S_PAYLOAD) || (state_q == S_EOF);
    assign cmd_legal = (rx_data >= DW'(1)) && (rx_data <= DW'(5));
    assign rx_cmd    = cmd_e'(rx_data[2:0]);

    mxv_frame_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .reload (rx_valid),
        .run    (tmo_run),
        .expire (tmo_expire)
    );

    always_comb begin
        state_nxt  = state_q;
        cmd_nxt    = cmd_q;
        len_nxt    = len_q;
        rem_nxt    = rem_q;
        narg_nxt   = narg_q;
        col_nxt    = col_q;
        row_nxt    = row_q;
        m_ok_nxt   = m_ok;
        v_ok_nxt   = v_ok;
        n_nxt      = n_cfg;
        code_nxt   = cmd_code;
        busy_nxt   = busy;
        data_nxt   = fifo_data;
        push_nxt   = '0;
        clr_nxt    = 1'b0;
        start_nxt  = 1'b0;
        resend_nxt = 1'b0;
        err_nxt    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == DW'(SOF)) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (rx_data == '0) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        len_nxt   = rx_data;
                        state_nxt = S_CMD;
                    end
                end
            end
            S_CMD: begin
                if (rx_valid) begin
                    if (!cmd_legal || len_q != DW'(expected_len(rx_cmd, n_cfg))) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        cmd_nxt   = rx_cmd;
                        rem_nxt   = len_q - DW'(1);
                        col_nxt   = '0;
                        row_nxt   = '0;
                        state_nxt = (len_q == DW'(1)) ? S_EOF : S_PAYLOAD;
                        if (rx_cmd == CMD_LOAD_M) begin
                            clr_nxt  = 1'b1;
                            m_ok_nxt = 1'b0;
                        end
                        if (rx_cmd == CMD_LOAD_V) begin
                            clr_nxt  = 1'b1;
                            v_ok_nxt = 1'b0;
                        end
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    data_nxt = rx_data;
                    case (cmd_q)
                        CMD_LOAD_M: begin
                            push_nxt = PW'(1) << row_q;
                            // Row-major walk: column wraps at N-1 and bumps the row.
                            if (col_q == n_cfg - 4'd1) begin
                                col_nxt = '0;
                                row_nxt = row_q + 4'd1;
                            end else begin
                                col_nxt = col_q + 4'd1;
                            end
                        end
                        CMD_LOAD_V: push_nxt = PW'(1) << MAX_N;
                        CMD_SET_N:  narg_nxt = rx_data;
                        default:    ;
                    endcase
                    rem_nxt = rem_q - DW'(1);
                    if (rem_q == DW'(1)) state_nxt = S_EOF;
                end
            end
            S_EOF: begin
                if (rx_valid) begin
                    if (rx_data == DW'(EOF)) begin
                        state_nxt = S_EXEC;
                    end else begin
                        err_nxt   = 1'b1;
                        clr_nxt   = 1'b1;
                        m_ok_nxt  = 1'b0;
                        v_ok_nxt  = 1'b0;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_EXEC: begin
                state_nxt = S_IDLE;
                code_nxt  = cmd_q;
                case (cmd_q)
                    CMD_SET_N: begin
                        if (narg_q < DW'(2) || narg_q > DW'(MAX_N)) begin
                            err_nxt  = 1'b1;
                            code_nxt = cmd_code;
                        end else begin
                            n_nxt    = narg_q[3:0];
                            clr_nxt  = 1'b1;
                            m_ok_nxt = 1'b0;
                            v_ok_nxt = 1'b0;
                        end
                    end
                    CMD_LOAD_M: m_ok_nxt   = 1'b1;
                    CMD_LOAD_V: v_ok_nxt   = 1'b1;
                    CMD_RESEND: resend_nxt = 1'b1;
                    CMD_START: begin
                        if (m_ok && v_ok) begin
                            start_nxt = 1'b1;
                            busy_nxt  = 1'b1;
                            state_nxt = S_WAIT_DONE;
                        end else begin
                            err_nxt  = 1'b1;
                            code_nxt = cmd_code;
                        end
                    end
                    default: code_nxt = cmd_code;
                endcase
            end
            S_WAIT_DONE: begin
                // A new frame start during compute is flagged; any other byte is dropped.
                if (rx_valid && rx_data == DW'(SOF)) err_nxt = 1'b1;
                if (mxv_done) begin
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (tmo_expire) begin
            err_nxt   = 1'b1;
            clr_nxt   = 1'b1;
            m_ok_nxt  = 1'b0;
            v_ok_nxt  = 1'b0;
            push_nxt  = '0;
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= CMD_NONE;
            len_q     <= '0;
            rem_q     <= '0;
            narg_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            m_ok      <= 1'b0;
            v_ok      <= 1'b0;
            n_cfg     <= 4'd2;
            cmd_code  <= 3'd0;
            busy      <= 1'b0;
            fifo_data <= '0;
            push_sel  <= '0;
            fifo_clr  <= 1'b0;
            mxv_start <= 1'b0;
            resend    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cmd_q     <= cmd_nxt;
            len_q     <= len_nxt;
            rem_q     <= rem_nxt;
            narg_q    <= narg_nxt;
            col_q     <= col_nxt;
            row_q     <= row_nxt;
            m_ok      <= m_ok_nxt;
            v_ok      <= v_ok_nxt;
            n_cfg     <= n_nxt;
            cmd_code  <= code_nxt;
            busy      <= busy_nxt;
            fifo_data <= data_nxt;
            push_sel  <= push_nxt;
            fifo_clr  <= clr_nxt;
            mxv_start <= start_nxt;
            resend    <= resend_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mxv_cmd_sequencer.sv
// Bench for mxv_cmd_sequencer: directed frames plus random frames scored against a frame-level model.
module tb_mxv_cmd_sequencer;

    localparam int DW    = 8;
    localparam int MAX_N = 8;
    localparam int TMO   = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    rx_data;
    logic             rx_valid;
    logic             mxv_done;
    logic [DW-1:0]    fifo_data;
    logic [MAX_N:0]   push_sel;
    logic             fifo_clr;
    logic [3:0]       n_cfg;
    logic             mxv_start;
    logic             resend;
    logic [2:0]       cmd_code;
    logic             busy;
    logic             err;

    always #5 clk = ~clk;

    mxv_cmd_sequencer #(.DW(DW), .MAX_N(MAX_N), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mxv_done  (mxv_done),
        .fifo_data (fifo_data),
        .push_sel  (push_sel),
        .fifo_clr  (fifo_clr),
        .n_cfg     (n_cfg),
        .mxv_start (mxv_start),
        .resend    (resend),
        .cmd_code  (cmd_code),
        .busy      (busy),
        .err       (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observed activity since the last clear_obs
    int          mon_err, mon_clr, mon_start, mon_resend;
    int          got_sel[$];
    logic [7:0]  got_dat[$];
    logic        prev_vld = 1'b0;
    logic [7:0]  prev_dat = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (err)       mon_err++;
            if (fifo_clr)  mon_clr++;
            if (mxv_start) mon_start++;
            if (resend)    mon_resend++;
            if (push_sel != '0) begin
                n_checks++;
                if ($countones(push_sel) != 1 || !prev_vld || fifo_data !== prev_dat)
                    $display("FAIL push_timing sel=%b data=%h prev_vld=%b prev_byte=%h", push_sel, fifo_data, prev_vld, prev_dat);
                else
                    n_pass++;
                for (int i = 0; i <= MAX_N; i++) if (push_sel[i]) got_sel.push_back(i);
                got_dat.push_back(fifo_data);
            end
            if (err) begin
                n_checks++;
                if (mxv_start || resend)
                    $display("FAIL err_exclusive start=%b resend=%b", mxv_start, resend);
                else
                    n_pass++;
            end
        end
        prev_vld = rx_valid;
        prev_dat = rx_data;
    end

    // Frame-level reference model
    int          m_n = 2;
    bit          m_mok, m_vok, m_busy;
    int          m_code;
    int          e_err, e_clr, e_start, e_resend;
    int          e_sel[$];
    logic [7:0]  e_dat[$];
    logic [7:0]  frame[$];

    task automatic model_reset();
        m_n = 2; m_mok = 0; m_vok = 0; m_busy = 0; m_code = 0;
    endtask

    task automatic model_frame();
        int len, cmd, need, arg;
        e_err = 0; e_clr = 0; e_start = 0; e_resend = 0;
        e_sel.delete(); e_dat.delete();
        if (m_busy) begin e_err = 1; return; end
        len = frame[1];
        if (len == 0) begin e_err = 1; return; end
        cmd = frame[2];
        case (cmd)
            1:       need = 2;
            2, 3:    need = 1;
            4:       need = 1 + m_n * m_n;
            5:       need = 1 + m_n;
            default: need = -1;
        endcase
        if (need != len) begin e_err = 1; return; end
        if (cmd == 4) begin e_clr++; m_mok = 0; end
        if (cmd == 5) begin e_clr++; m_vok = 0; end
        for (int k = 0; k < len - 1; k++) begin
            if (cmd == 4) begin e_sel.push_back(k / m_n); e_dat.push_back(frame[3+k]); end
            if (cmd == 5) begin e_sel.push_back(MAX_N);   e_dat.push_back(frame[3+k]); end
        end
        if (frame[2+len] != 8'hEF) begin
            e_err = 1; e_clr++; m_mok = 0; m_vok = 0;
            return;
        end
        case (cmd)
            1: begin
                arg = frame[3];
                if (arg < 2 || arg > MAX_N) e_err = 1;
                else begin m_n = arg; e_clr++; m_mok = 0; m_vok = 0; m_code = 1; end
            end
            2: begin e_resend = 1; m_code = 2; end
            3: begin
                if (m_mok && m_vok) begin e_start = 1; m_busy = 1; m_code = 3; end
                else e_err = 1;
            end
            4: begin m_mok = 1; m_code = 4; end
            5: begin m_vok = 1; m_code = 5; end
            default: ;
        endcase
    endtask

    task automatic clear_obs();
        mon_err = 0; mon_clr = 0; mon_start = 0; mon_resend = 0;
        got_sel.delete(); got_dat.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        clear_obs();
        model_frame();
        foreach (frame[i]) begin
            send_byte(frame[i]);
            tick($urandom_range(0, 2));
        end
        tick(4);
    endtask

    task automatic pulse_done();
        mxv_done = 1'b1;
        tick(1);
        mxv_done = 1'b0;
        tick(2);
        m_busy = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; mxv_done = 1'b0; rx_data = '0;
        tick(3);
        n_checks++;
        if (n_cfg !== 4'd2 || cmd_code !== 3'd0 || busy !== 1'b0) $display("FAIL reset_state n_cfg=%0d cmd_code=%0d busy=%b want 2/0/0", n_cfg, cmd_code, busy);
        else n_pass++;
        n_checks++;
        if ({push_sel, fifo_clr, mxv_start, resend, err} !== '0) $display("FAIL reset_pulses got=%b want 0", {push_sel, fifo_clr, mxv_start, resend, err});
        else n_pass++;
        rst = 1'b0;
        model_reset();
        tick(1);
    endtask

    task automatic test_set_n();
        frame = '{8'hFE, 8'h02, 8'h01, 8'h03, 8'hEF};
        send_frame();
        n_checks++;
        if (n_cfg !== 4'd3 || cmd_code !== 3'd1) $display("FAIL set_n n_cfg=%0d cmd_code=%0d want 3/1", n_cfg, cmd_code); else n_pass++;
        n_checks++;
        if (mon_clr !== 1 || mon_err !== 0) $display("FAIL set_n_pulses clr=%0d err=%0d want 1/0", mon_clr, mon_err); else n_pass++;
    endtask

    task automatic test_load_m();
        int bad;
        frame = '{8'hFE, 8'h0A, 8'h04, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8, 8'hB9, 8'hEF};
        send_frame();
        n_checks++;
        if (got_sel.size() !== 9) $display("FAIL load_m_count got=%0d want 9", got_sel.size()); else n_pass++;
        bad = 0;
        for (int k = 0; k < 9 && k < got_sel.size(); k++)
            if (got_sel[k] != k / 3 || got_dat[k] != 8'(8'hB1 + k)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL load_m_rows mismatching_pushes=%0d want 0", bad); else n_pass++;
        n_checks++;
        if (cmd_code !== 3'd4 || mon_clr !== 1) $display("FAIL load_m_exec cmd_code=%0d clr=%0d want 4/1", cmd_code, mon_clr); else n_pass++;
    endtask

    task automatic test_start_busy();
        frame = '{8'hFE, 8'h04, 8'h05, 8'h21, 8'h22, 8'h23, 8'hEF};
        send_frame();
        n_checks++;
        if (got_sel.size() !== 3 || cmd_code !== 3'd5) $display("FAIL load_v pushes=%0d cmd_code=%0d want 3/5", got_sel.size(), cmd_code); else n_pass++;
        frame = '{8'hFE, 8'h01, 8'h03, 8'hEF};
        send_frame();
        n_checks++;
        if (mon_start !== 1 || busy !== 1'b1 || mon_err !== 0) $display("FAIL start start_cycles=%0d busy=%b err=%0d want 1/1/0", mon_start, busy, mon_err); else n_pass++;
        frame = '{8'hFE};
        send_frame();
        n_checks++;
        if (mon_err !== 1 || busy !== 1'b1) $display("FAIL sof_while_busy err=%0d busy=%b want 1/1", mon_err, busy); else n_pass++;
        pulse_done();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL done_clears_busy busy=%b want 0", busy); else n_pass++;
    endtask

    task automatic test_errors();
        frame = '{8'hFE, 8'h02, 8'h01, 8'h03, 8'hEF};
        send_frame();
        frame = '{8'hFE, 8'h01, 8'h03, 8'hEF};
        send_frame();
        n_checks++;
        if (mon_err !== 1 || mon_start !== 0) $display("FAIL start_not_loaded err=%0d start=%0d want 1/0", mon_err, mon_start); else n_pass++;
        frame = '{8'hFE, 8'h02, 8'h01, 8'h09, 8'hEF};
        send_frame();
        n_checks++;
        if (mon_err !== 1 || n_cfg !== 4'd3) $display("FAIL set_n_range err=%0d n_cfg=%0d want 1/3", mon_err, n_cfg); else n_pass++;
        frame = '{8'hFE, 8'h00};
        send_frame();
        n_checks++;
        if (mon_err !== 1) $display("FAIL len_zero err=%0d want 1", mon_err); else n_pass++;
    endtask

    task automatic test_bad_eof();
        frame = '{8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF};
        send_frame();
        frame = '{8'hFE, 8'h03, 8'h05, 8'hAA, 8'hBB, 8'hEF};
        send_frame();
        frame = '{8'hFE, 8'h05, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_frame();
        n_checks++;
        if (mon_err !== 1 || mon_clr !== 2 || got_sel.size() !== 4) $display("FAIL bad_eof err=%0d clr=%0d pushes=%0d want 1/2/4", mon_err, mon_clr, got_sel.size()); else n_pass++;
        frame = '{8'hFE, 8'h01, 8'h03, 8'hEF};
        send_frame();
        n_checks++;
        if (mon_err !== 1 || mon_start !== 0) $display("FAIL bad_eof_flags err=%0d start=%0d want 1/0", mon_err, mon_start); else n_pass++;
    endtask

    task automatic test_timeout();
        int seen;
        clear_obs();
        send_byte(8'hFE);
        send_byte(8'h03);
        seen = -1;
        for (int k = 1; k <= TMO + 5 && seen < 0; k++) begin
            tick(1);
            if (mon_err != 0) seen = k;
        end
        m_mok = 0; m_vok = 0;
        n_checks++;
        if (seen < TMO - 1 || seen > TMO + 2) $display("FAIL timeout err_after=%0d cycles want %0d..%0d", seen, TMO - 1, TMO + 2); else n_pass++;
        n_checks++;
        if (mon_clr !== 1) $display("FAIL timeout_clr clr=%0d want 1", mon_clr); else n_pass++;
        frame = '{8'hFE, 8'h01, 8'h02, 8'hEF};
        send_frame();
        n_checks++;
        if (mon_resend !== 1 || mon_err !== 0 || cmd_code !== 3'd2) $display("FAIL resend resend=%0d err=%0d cmd_code=%0d want 1/0/2", mon_resend, mon_err, cmd_code); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        clear_obs();
        send_byte(8'hFE); send_byte(8'h05); send_byte(8'h04); send_byte(8'h11);
        do_reset();
        clear_obs();
        tick(3);
        n_checks++;
        if (got_sel.size() !== 0 || n_cfg !== 4'd2 || mon_err !== 0) $display("FAIL rst_midframe pushes=%0d n_cfg=%0d err=%0d want 0/2/0", got_sel.size(), n_cfg, mon_err); else n_pass++;
        frame = '{8'hFE, 8'h05, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hEF}; send_frame();
        frame = '{8'hFE, 8'h03, 8'h05, 8'h05, 8'h06, 8'hEF};               send_frame();
        frame = '{8'hFE, 8'h01, 8'h03, 8'hEF};                             send_frame();
        do_reset();
        clear_obs();
        tick(3);
        n_checks++;
        if (busy !== 1'b0 || mon_start !== 0 || cmd_code !== 3'd0) $display("FAIL rst_midcompute busy=%b start=%0d cmd_code=%0d want 0/0/0", busy, mon_start, cmd_code); else n_pass++;
    endtask

    task automatic test_random();
        int cmd, len, corrupt, bad;
        for (int it = 0; it < 40; it++) begin
            if (!m_busy && $urandom_range(0, 3) == 0) pulse_done();
            cmd     = $urandom_range(1, 5);
            corrupt = $urandom_range(0, 9);
            case (cmd)
                1:       len = 2;
                2, 3:    len = 1;
                4:       len = 1 + m_n * m_n;
                default: len = 1 + m_n;
            endcase
            if (corrupt == 0) len = len + 1;
            if (corrupt == 1) begin cmd = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(6, 7); len = $urandom_range(1, 3); end
            frame = '{8'hFE, 8'(len), 8'(cmd)};
            for (int k = 0; k < len - 1; k++)
                frame.push_back((cmd == 1) ? 8'($urandom_range(1, 9)) : 8'($urandom_range(0, 8'hFD)));
            frame.push_back((corrupt == 2) ? 8'($urandom_range(0, 8'hEE)) : 8'hEF);
            send_frame();
            n_checks++;
            if (mon_err != e_err || mon_clr != e_clr) $display("FAIL rnd_err_clr it=%0d err=%0d clr=%0d want %0d/%0d", it, mon_err, mon_clr, e_err, e_clr); else n_pass++;
            n_checks++;
            if (mon_start != e_start || mon_resend != e_resend) $display("FAIL rnd_start_resend it=%0d start=%0d resend=%0d want %0d/%0d", it, mon_start, mon_resend, e_start, e_resend); else n_pass++;
            bad = (got_sel.size() != e_sel.size()) ? 1 : 0;
            for (int k = 0; k < e_sel.size() && k < got_sel.size(); k++)
                if (got_sel[k] != e_sel[k] || got_dat[k] != e_dat[k]) bad++;
            n_checks++;
            if (bad != 0) $display("FAIL rnd_pushes it=%0d got=%0d want=%0d mismatches=%0d", it, got_sel.size(), e_sel.size(), bad); else n_pass++;
            n_checks++;
            if (n_cfg !== 4'(m_n) || cmd_code !== 3'(m_code) || busy !== m_busy) $display("FAIL rnd_state it=%0d n_cfg=%0d cmd_code=%0d busy=%b want %0d/%0d/%b", it, n_cfg, cmd_code, busy, m_n, m_code, m_busy); else n_pass++;
            if (m_busy) begin
                if ($urandom_range(0, 1) == 1) begin
                    frame = '{8'hFE};
                    send_frame();
                    n_checks++;
                    if (mon_err != 1) $display("FAIL rnd_busy_sof it=%0d err=%0d want 1", it, mon_err); else n_pass++;
                end
                pulse_done();
                n_checks++;
                if (busy !== 1'b0) $display("FAIL rnd_done it=%0d busy=%b want 0", it, busy); else n_pass++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_set_n();
        test_load_m();
        test_start_busy();
        test_errors();
        test_bad_eof();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
